uart_ram_cmd_ctrl: RTL

Byte-command controller between the UART byte interface and the single-port frame buffer RAM. It decodes host command bytes and runs these operations: ping, address set/reset/step/report, single-byte read, and fixed-length burst write and burst read. Burst length, address width and RAM depth are parameters. A burst write that stalls is aborted after a timeout. Overrun errors are flagged.

---
 rtl/uart_cmd_pkg.sv | 27 ++
 rtl/cmd_timeout_cnt.sv | 38 +++
 rtl/uart_ram_cmd_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART byte-command RAM controller:
// command codes, FSM state encoding and address byte-count helper.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_PING     = 8'h55;
    localparam logic [7:0] CMD_ADDR_RST = 8'hBB;
    localparam logic [7:0] CMD_ADDR_INC = 8'hDD;
    localparam logic [7:0] CMD_ADDR_RPT = 8'hAA;
    localparam logic [7:0] CMD_ADDR_SET = 8'h99;
    localparam logic [7:0] CMD_RD       = 8'hCC;
    localparam logic [7:0] CMD_BWR      = 8'hFF;
    localparam logic [7:0] CMD_BRD      = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETADDR,
        ST_WR_WAIT,
        ST_WR_STORE,
        ST_RD_LAT,
        ST_TX_HOLD
    } state_e;

    function automatic int addr_bytes(input int w);
        return (w + 7) / 8;
    endfunction

endpackage

// File: rtl/cmd_timeout_cnt.sv
// Loadable down-counter; strobes expired_o on the last enabled cycle
// of a TIMEOUT_CYC-long run of enabled cycles without a reload.
module cmd_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYC = 24_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYC);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == CW'(1));

endmodule

// File: rtl/uart_ram_cmd_ctrl.sv
// Byte-command controller between a UART byte stream and a single-port
// frame buffer RAM: ping, address ops, single read, burst write/read.
module uart_ram_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int          ADDR_W      = 15,
    parameter int          DEPTH       = 2**ADDR_W,
    parameter int          BURST_LEN   = 102,
    parameter int          TIMEOUT_CYC = 24_000_000,
    parameter logic [7:0]  PING_REPLY  = 8'h44
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata,
    output logic              busy,
    output logic              err_pulse
);

    localparam int AB = addr_bytes(ADDR_W);
    localparam int SW = AB * 8;
    localparam int CW = $clog2(BURST_LEN + AB + 1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CW-1:0]     cnt_q;
    logic [SW-1:0]     sh_q;
    logic              burst_q;
    logic              tx_valid_q;
    logic [7:0]        tx_data_q;
    logic              we_q;
    logic [7:0]        wdata_q;
    logic              err_q;

    logic [SW-1:0] sh_in;
    logic [SW-1:0] addr_ext;
    logic          tmo_en;
    logic          tmo_exp;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return (a == LAST) ? '0 : a + ADDR_W'(1);
    endfunction

    // Address bytes arrive LSB first, so each new byte enters at the top.
    assign sh_in    = SW'({rx_data, sh_q} >> 8);
    assign addr_ext = SW'(addr_q);
    assign tmo_en   = (state_q == ST_WR_WAIT || state_q == ST_SETADDR) && !rx_valid;

    cmd_timeout_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_tmo (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (!tmo_en),
        .en_i     (tmo_en),
        .expired_o(tmo_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            sh_q       <= '0;
            burst_q    <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            we_q  <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            CMD_PING: begin
                                tx_valid_q <= 1'b1;
                                tx_data_q  <= PING_REPLY;
                                cnt_q      <= '0;
                                burst_q    <= 1'b0;
                                state_q    <= ST_TX_HOLD;
                            end
                            CMD_ADDR_RST: addr_q <= '0;
                            CMD_ADDR_INC: addr_q <= addr_inc(addr_q);
                            CMD_ADDR_RPT: begin
                                tx_valid_q <= 1'b1;
                                tx_data_q  <= addr_ext[7:0];
                                sh_q       <= addr_ext >> 8;
                                cnt_q      <= CW'(AB - 1);
                                burst_q    <= 1'b0;
                                state_q    <= ST_TX_HOLD;
                            end
                            CMD_ADDR_SET: begin
                                cnt_q   <= CW'(AB - 1);
                                state_q <= ST_SETADDR;
                            end
                            CMD_RD: begin
                                cnt_q   <= '0;
                                burst_q <= 1'b0;
                                state_q <= ST_RD_LAT;
                            end
                            CMD_BWR: begin
                                cnt_q   <= CW'(BURST_LEN - 1);
                                state_q <= ST_WR_WAIT;
                            end
                            CMD_BRD: begin
                                cnt_q   <= CW'(BURST_LEN - 1);
                                burst_q <= 1'b1;
                                state_q <= ST_RD_LAT;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_SETADDR: begin
                    if (rx_valid) begin
                        sh_q <= sh_in;
                        if (cnt_q == '0) begin
                            state_q <= ST_IDLE;
                            if (64'(sh_in) >= 64'(DEPTH)) begin
                                addr_q <= '0;
                                err_q  <= 1'b1;
                            end else begin
                                addr_q <= sh_in[ADDR_W-1:0];
                            end
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end else if (tmo_exp) begin
                        state_q <= ST_IDLE;
                        err_q   <= 1'b1;
                    end
                end
                ST_WR_WAIT: begin
                    if (rx_valid) begin
                        we_q    <= 1'b1;
                        wdata_q <= rx_data;
                        state_q <= ST_WR_STORE;
                    end else if (tmo_exp) begin
                        state_q <= ST_IDLE;
                        err_q   <= 1'b1;
                    end
                end
                ST_WR_STORE: begin
                    err_q  <= rx_valid;
                    addr_q <= addr_inc(addr_q);
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q   <= cnt_q - CW'(1);
                        state_q <= ST_WR_WAIT;
                    end
                end
                // Burst address advances at capture so the next read is
                // already in flight while this byte waits for the UART.
                ST_RD_LAT: begin
                    err_q      <= rx_valid;
                    tx_data_q  <= ram_rdata;
                    tx_valid_q <= 1'b1;
                    if (burst_q) begin
                        addr_q <= addr_inc(addr_q);
                    end
                    state_q <= ST_TX_HOLD;
                end
                ST_TX_HOLD: begin
                    err_q <= rx_valid;
                    if (tx_ready) begin
                        if (cnt_q == '0) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                            if (burst_q) begin
                                tx_valid_q <= 1'b0;
                                state_q    <= ST_RD_LAT;
                            end else begin
                                tx_data_q <= sh_q[7:0];
                                sh_q      <= sh_q >> 8;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_we    = we_q;
    assign busy      = (state_q != ST_IDLE);
    assign err_pulse = err_q;

endmodule
